// File: rtl/shift_seq_checker_if.sv
// Interface bundle between a shift-counter source and shift_seq_checker.
interface shift_seq_checker_if #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2*WIDTH)
);
    // en is a valid-only qualifier: there is no ready, the checker accepts
    // cnt_in on every clock where en=1 and ignores it otherwise.
    logic             en;
    logic [WIDTH-1:0] cnt_in;
    logic             clr_fault;
    logic [PW-1:0]    phase;
    logic             phase_valid;
    logic             wrap;
    logic             locked;
    logic             fault;
    logic [7:0]       err_cnt;
    logic [1:0]       state_dbg;

    modport master (
        output en, cnt_in, clr_fault,
        input  phase, phase_valid, wrap, locked, fault, err_cnt, state_dbg
    );

    modport slave (
        input  en, cnt_in, clr_fault,
        output phase, phase_valid, wrap, locked, fault, err_cnt, state_dbg
    );
endinterface

// File: rtl/shift_seq_checker.sv
// Checks a ring/Johnson shift-counter state stream: legality, phase decode,
// successor match, lock qualification and sticky fault on repeated errors.
module shift_seq_checker #(
    parameter int               WIDTH    = 4,
    parameter int               MODE     = 1,
    parameter logic [WIDTH-1:0] INIT     = WIDTH'(4'b1001),
    parameter int               LOCK_CNT = 3,
    parameter int               ERR_MAX  = 2
) (
    input logic clk,
    input logic rst,
    shift_seq_checker_if.slave bus
);
    localparam int PW   = $clog2(2*WIDTH);
    localparam int NPAT = (MODE != 0) ? 2*WIDTH : WIDTH;
    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] ERR_C  = 4'(ERR_MAX);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_LOCKED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] prev, prev_n;
    logic             prev_valid, prev_valid_n;
    logic [3:0]       match_cnt, match_n;
    logic [3:0]       miss_cnt, miss_n;
    logic [PW-1:0]    phase_q, phase_n;
    logic             pv_q, pv_n;
    logic             wrap_q, wrap_n;
    logic [7:0]       err_q, err_n;

    logic             legal;
    logic [PW-1:0]    dec;
    logic [WIDTH-1:0] expected;
    logic             good;

    // Counter state at phase k: Johnson fills 1s from the MSB then drains
    // them from the MSB; ring is INIT rotated right by k.
    function automatic logic [WIDTH-1:0] pattern(input int k);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MODE != 0)
                p[i] = (k <= WIDTH) ? (i >= WIDTH - k) : (i < 2*WIDTH - k);
            else
                p[i] = INIT[(i + k) % WIDTH];
        end
        return p;
    endfunction

    // Descending scan so the smallest matching k wins for symmetric INIT.
    always_comb begin
        legal = 1'b0;
        dec   = '0;
        for (int k = NPAT - 1; k >= 0; k--) begin
            if (bus.cnt_in == pattern(k)) begin
                legal = 1'b1;
                dec   = PW'(k);
            end
        end
    end

    assign expected = (MODE != 0) ? {~prev[0], prev[WIDTH-1:1]}
                                  : { prev[0], prev[WIDTH-1:1]};
    assign good     = legal && (!prev_valid || bus.cnt_in == expected);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_SEARCH;
            prev       <= '0;
            prev_valid <= 1'b0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            phase_q    <= '0;
            pv_q       <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            prev_valid <= prev_valid_n;
            match_cnt  <= match_n;
            miss_cnt   <= miss_n;
            phase_q    <= phase_n;
            pv_q       <= pv_n;
            wrap_q     <= wrap_n;
            err_q      <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        prev_n       = prev;
        prev_valid_n = prev_valid;
        match_n      = match_cnt;
        miss_n       = miss_cnt;
        phase_n      = phase_q;
        pv_n         = pv_q;
        wrap_n       = 1'b0;
        err_n        = err_q;

        if (bus.clr_fault) begin
            // Clear wins over a same-cycle sample.
            state_n      = S_SEARCH;
            prev_valid_n = 1'b0;
            match_n      = '0;
            miss_n       = '0;
            pv_n         = 1'b0;
            err_n        = '0;
        end else if (bus.en) begin
            prev_n       = bus.cnt_in;
            prev_valid_n = 1'b1;
            if (!good && prev_valid && err_q != 8'hFF)
                err_n = err_q + 8'd1;

            unique case (state)
                S_SEARCH: begin
                    pv_n = 1'b0;
                    if (good && prev_valid) begin
                        if (match_cnt + 4'd1 == LOCK_C) begin
                            state_n = S_LOCKED;
                            match_n = '0;
                            miss_n  = '0;
                        end else begin
                            match_n = match_cnt + 4'd1;
                        end
                    end else if (!good) begin
                        match_n = '0;
                    end
                end
                S_LOCKED: begin
                    if (good) begin
                        miss_n  = '0;
                        phase_n = dec;
                        pv_n    = 1'b1;
                        wrap_n  = (dec == '0);
                    end else begin
                        pv_n = 1'b0;
                        if (miss_cnt + 4'd1 == ERR_C) begin
                            state_n = S_FAULT;
                            miss_n  = '0;
                        end else begin
                            miss_n = miss_cnt + 4'd1;
                        end
                    end
                end
                S_FAULT: begin
                    pv_n = 1'b0;
                end
                default: begin
                    state_n = S_SEARCH;
                end
            endcase
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_valid = pv_q;
    assign bus.wrap        = wrap_q;
    assign bus.locked      = (state == S_LOCKED);
    assign bus.fault       = (state == S_FAULT);
    assign bus.err_cnt     = err_q;
    assign bus.state_dbg   = state;
endmodule
